// File: rtl/box_anim_pkg.sv
// Shared types and constants for the box animator: screen geometry,
// bus widths, FSM state encoding and the per-axis bounce step.
package box_anim_pkg;

    localparam int X_SCREEN_PIXELS = 160;
    localparam int Y_SCREEN_PIXELS = 120;
    localparam int BOX_SIZE        = 4;

    localparam int COORD_W  = 7;
    localparam int COLOUR_W = 3;

    // X is limited both by the screen and by the 7-bit coordinate bus.
    localparam int X_MAX_INT = ((X_SCREEN_PIXELS - BOX_SIZE) > 127) ? 127
                                                                     : (X_SCREEN_PIXELS - BOX_SIZE);
    localparam int Y_MAX_INT = Y_SCREEN_PIXELS - BOX_SIZE;

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(X_MAX_INT);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(Y_MAX_INT);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_DRAW_X     = 4'd1,
        ST_DRAW_GAP   = 4'd2,
        ST_DRAW_Y     = 4'd3,
        ST_DRAW_WAIT  = 4'd4,
        ST_WAIT_FRAME = 4'd5,
        ST_ERASE_X    = 4'd6,
        ST_ERASE_GAP  = 4'd7,
        ST_ERASE_Y    = 4'd8,
        ST_ERASE_WAIT = 4'd9,
        ST_MOVE       = 4'd10
    } state_t;

    // One bounce step for an axis. Returns {new_dir, new_pos}; at an edge
    // the direction flips and the position steps back inside in the same move.
    function automatic logic [COORD_W:0] step_axis(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [COORD_W-1:0] max_pos
    );
        logic [COORD_W:0] res;
        if (dir && (pos == max_pos)) begin
            res = {1'b0, pos - COORD_W'(1)};
        end else if (!dir && (pos == {COORD_W{1'b0}})) begin
            res = {1'b1, pos + COORD_W'(1)};
        end else if (dir) begin
            res = {1'b1, pos + COORD_W'(1)};
        end else begin
            res = {1'b0, pos - COORD_W'(1)};
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and emits a registered
// one-cycle tick while the count sits at FRAME_DIV-1.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833334
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             tick_r;
    logic             tick_s;

    // Next count with wrap; tick is aligned with the cycle the count is at its last value.
    always_comb begin
        if (cnt_r == CNT_LAST) begin
            cnt_s = {CNT_W{1'b0}};
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end
        tick_s = (cnt_s == CNT_LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            tick_r <= tick_s;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/box_animator.sv
// Box animator: drives the plotter's load/plot handshake to erase, step and
// redraw a box that bounces diagonally around the screen.
module box_animator
    import box_anim_pkg::*;
#(
    parameter int FRAME_DIV       = 833334,
    parameter int FRAMES_PER_MOVE = 15,
    parameter int DRAW_WAIT       = 24
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iEnable,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iDone,
    output logic                oLoadX,
    output logic                oPlotBox,
    output logic [COORD_W-1:0]  oXY_Coord,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oBusy
);

    localparam int WAIT_W  = $clog2(DRAW_WAIT + 1);
    localparam int FRAME_W = $clog2(FRAMES_PER_MOVE + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(DRAW_WAIT - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_MOVE - 1);

    state_t               state_r;
    state_t               state_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [WAIT_W-1:0]    wait_cnt_s;
    logic [FRAME_W-1:0]   frame_cnt_r;
    logic [FRAME_W-1:0]   frame_cnt_s;
    logic [COORD_W-1:0]   x_r;
    logic [COORD_W-1:0]   y_r;
    logic                 dx_r;
    logic                 dy_r;
    logic [COORD_W:0]     step_x_s;
    logic [COORD_W:0]     step_y_s;
    logic                 tick_s;
    logic                 wait_done_s;
    logic                 in_wait_s;

    logic                 load_x_r,   load_x_s;
    logic                 plot_box_r, plot_box_s;
    logic [COORD_W-1:0]   xy_r,       xy_s;
    logic [COLOUR_W-1:0]  colour_r,   colour_s;
    logic                 busy_r,     busy_s;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick (
        .clk   (iClock),
        .rst_n (iResetn),
        .tick  (tick_s)
    );

    assign in_wait_s   = (state_r == ST_DRAW_WAIT) || (state_r == ST_ERASE_WAIT);
    // The counter guarantees the minimum wait even when iDone is left high.
    assign wait_done_s = (wait_cnt_r >= WAIT_LAST) && iDone;
    assign step_x_s    = step_axis(x_r, dx_r, X_MAX);
    assign step_y_s    = step_axis(y_r, dy_r, Y_MAX);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iEnable) begin
                    state_s = ST_DRAW_X;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAW_X:   state_s = ST_DRAW_GAP;
            ST_DRAW_GAP: state_s = ST_DRAW_Y;
            ST_DRAW_Y:   state_s = ST_DRAW_WAIT;
            ST_DRAW_WAIT: begin
                if (wait_done_s) begin
                    state_s = iEnable ? ST_WAIT_FRAME : ST_IDLE;
                end else begin
                    state_s = ST_DRAW_WAIT;
                end
            end
            ST_WAIT_FRAME: begin
                if (!iEnable) begin
                    state_s = ST_IDLE;
                end else if (tick_s && (frame_cnt_r == FRAME_LAST)) begin
                    state_s = ST_ERASE_X;
                end else begin
                    state_s = ST_WAIT_FRAME;
                end
            end
            ST_ERASE_X:   state_s = ST_ERASE_GAP;
            ST_ERASE_GAP: state_s = ST_ERASE_Y;
            ST_ERASE_Y:   state_s = ST_ERASE_WAIT;
            ST_ERASE_WAIT: begin
                if (wait_done_s) begin
                    state_s = ST_MOVE;
                end else begin
                    state_s = ST_ERASE_WAIT;
                end
            end
            ST_MOVE:  state_s = ST_DRAW_X;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Wait and frame counters: both are held at zero outside their own states.
    always_comb begin
        wait_cnt_s  = {WAIT_W{1'b0}};
        frame_cnt_s = {FRAME_W{1'b0}};
        if (in_wait_s) begin
            if (wait_cnt_r < WAIT_LAST) begin
                wait_cnt_s = wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_s = wait_cnt_r;
            end
        end else begin
            wait_cnt_s = {WAIT_W{1'b0}};
        end
        if (state_r == ST_WAIT_FRAME) begin
            if (tick_s) begin
                frame_cnt_s = frame_cnt_r + FRAME_W'(1);
            end else begin
                frame_cnt_s = frame_cnt_r;
            end
        end else begin
            frame_cnt_s = {FRAME_W{1'b0}};
        end
    end

    // Output values derived from the current state; registered below.
    always_comb begin
        load_x_s   = 1'b0;
        plot_box_s = 1'b0;
        xy_s       = xy_r;
        colour_s   = colour_r;
        busy_s     = (state_r != ST_IDLE) && (state_r != ST_WAIT_FRAME);
        case (state_r)
            ST_DRAW_X, ST_ERASE_X: begin
                load_x_s = 1'b1;
                xy_s     = x_r;
            end
            ST_DRAW_Y: begin
                plot_box_s = 1'b1;
                xy_s       = y_r;
                colour_s   = iColour;
            end
            ST_ERASE_Y: begin
                plot_box_s = 1'b1;
                xy_s       = y_r;
                colour_s   = {COLOUR_W{1'b0}};
            end
            default: begin
                load_x_s   = 1'b0;
                plot_box_s = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            frame_cnt_r <= {FRAME_W{1'b0}};
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            frame_cnt_r <= frame_cnt_s;
        end
    end

    // Position and direction: only change in MOVE, otherwise retained.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            x_r  <= {COORD_W{1'b0}};
            y_r  <= {COORD_W{1'b0}};
            dx_r <= 1'b1;
            dy_r <= 1'b1;
        end else if (state_r == ST_MOVE) begin
            {dx_r, x_r} <= step_x_s;
            {dy_r, y_r} <= step_y_s;
        end
    end

    // Output registers; reset clears strobes immediately so no partial strobe escapes.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            load_x_r   <= 1'b0;
            plot_box_r <= 1'b0;
            xy_r       <= {COORD_W{1'b0}};
            colour_r   <= {COLOUR_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            load_x_r   <= load_x_s;
            plot_box_r <= plot_box_s;
            xy_r       <= xy_s;
            colour_r   <= colour_s;
            busy_r     <= busy_s;
        end
    end

    assign oLoadX    = load_x_r;
    assign oPlotBox  = plot_box_r;
    assign oXY_Coord = xy_r;
    assign oColour   = colour_r;
    assign oBusy     = busy_r;

endmodule

// File: tb/tb_box_animator.sv
// Scoreboard bench for box_animator: expected strobes are queued when a move
// or draw is requested and checked as the DUT emits them.
module tb_box_animator;

    typedef struct packed {
        logic       is_plot;
        logic [6:0] coord;
        logic [2:0] colour;
    } strobe_t;

    logic       iClock = 1'b0;
    logic       iResetn;
    logic       iEnable;
    logic [2:0] iColour;
    logic       iDone = 1'b0;
    logic       oLoadX;
    logic       oPlotBox;
    logic [6:0] oXY_Coord;
    logic [2:0] oColour;
    logic       oBusy;

    strobe_t exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int last_load_cyc = -1000;
    int last_plot_cyc = -1000;

    // Reference position model
    int m_x, m_y;
    bit m_dx, m_dy;

    box_animator #(
        .FRAME_DIV       (4),
        .FRAMES_PER_MOVE (2),
        .DRAW_WAIT       (24)
    ) dut (
        .iClock    (iClock),
        .iResetn   (iResetn),
        .iEnable   (iEnable),
        .iColour   (iColour),
        .iDone     (iDone),
        .oLoadX    (oLoadX),
        .oPlotBox  (oPlotBox),
        .oXY_Coord (oXY_Coord),
        .oColour   (oColour),
        .oBusy     (oBusy)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) cyc++;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: pop expected strobe on each DUT strobe; model sticky iDone.
    always @(negedge iClock) begin
        strobe_t e;
        if (oLoadX || oPlotBox) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_value("strobe_kind", {31'd0, oPlotBox}, {31'd0, e.is_plot});
                check_value("coord", {25'd0, oXY_Coord}, {25'd0, e.coord});
                if (e.is_plot) begin
                    check_value("plot_colour", {29'd0, oColour}, {29'd0, e.colour});
                    check_value("load_to_plot_gap", cyc - last_load_cyc, 32'd2);
                    last_plot_cyc = cyc;
                    iDone = 1'b1;
                end else begin
                    check_value("plot_to_load_ge24", {31'd0, (cyc - last_plot_cyc) >= 24}, 32'd1);
                    last_load_cyc = cyc;
                end
            end
        end
    end

    task automatic push_draw(input logic [2:0] col);
        strobe_t s;
        s = '{is_plot: 1'b0, coord: 7'(m_x), colour: 3'd0};
        exp_q.push_back(s);
        s = '{is_plot: 1'b1, coord: 7'(m_y), colour: col};
        exp_q.push_back(s);
    endtask

    task automatic push_erase();
        push_draw(3'd0);
    endtask

    task automatic model_move();
        if (m_dx) begin
            if (m_x == 127) begin m_dx = 1'b0; m_x = m_x - 1; end
            else m_x = m_x + 1;
        end else begin
            if (m_x == 0) begin m_dx = 1'b1; m_x = m_x + 1; end
            else m_x = m_x - 1;
        end
        if (m_dy) begin
            if (m_y == 116) begin m_dy = 1'b0; m_y = m_y - 1; end
            else m_y = m_y + 1;
        end else begin
            if (m_y == 0) begin m_dy = 1'b1; m_y = m_y + 1; end
            else m_y = m_y - 1;
        end
    endtask

    task automatic do_move(input logic [2:0] col);
        push_erase();
        model_move();
        push_draw(col);
    endtask

    task automatic wait_q_size(input int target, input string tag);
        int n = 0;
        while (exp_q.size() > target && n < 2000) begin
            @(negedge iClock); #1;
            n++;
        end
        check_value(tag, exp_q.size(), target);
    endtask

    task automatic wait_frame_state(input string tag);
        int n = 0;
        while (oBusy !== 1'b0 && n < 200) begin
            @(negedge iClock); #1;
            n++;
        end
        check_value(tag, {31'd0, oBusy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_loadx"},  {31'd0, oLoadX},    32'd0);
        check_value({tag, "_plot"},   {31'd0, oPlotBox},  32'd0);
        check_value({tag, "_coord"},  {25'd0, oXY_Coord}, 32'd0);
        check_value({tag, "_colour"}, {29'd0, oColour},   32'd0);
        check_value({tag, "_busy"},   {31'd0, oBusy},     32'd0);
    endtask

    initial begin
        int c0;
        m_x = 0; m_y = 0; m_dx = 1'b1; m_dy = 1'b1;
        iResetn = 1'b0;
        iEnable = 1'b0;
        iColour = 3'b101;
        repeat (3) @(negedge iClock);
        #1;
        check_outputs_zero("reset");
        iResetn = 1'b1;
        repeat (2) @(negedge iClock);
        #1;

        // First draw and enable-to-strobe latency
        c0 = cyc;
        push_draw(3'b101);
        iEnable = 1'b1;
        wait_q_size(0, "first_draw_drain");
        check_value("enable_to_loadx_latency", last_load_cyc - c0, 32'd2);

        // Move cadence from (0,0)
        for (int i = 0; i < 3; i++) begin
            wait_frame_state("cadence_wait_frame");
            do_move(3'b101);
            wait_q_size(0, "cadence_drain");
        end

        // X bounce at the right edge
        wait_frame_state("xbounce_wait_frame");
        force dut.x_r  = 7'd127;
        force dut.dx_r = 1'b1;
        force dut.y_r  = 7'd50;
        force dut.dy_r = 1'b1;
        @(negedge iClock);
        release dut.x_r;
        release dut.dx_r;
        release dut.y_r;
        release dut.dy_r;
        m_x = 127; m_dx = 1'b1; m_y = 50; m_dy = 1'b1;
        do_move(3'b101);
        wait_q_size(0, "xbounce_drain1");
        check_value("xbounce_x1", m_x, 32'd126);
        wait_frame_state("xbounce_wait_frame2");
        do_move(3'b101);
        wait_q_size(0, "xbounce_drain2");

        // Corner: both axes flip together
        wait_frame_state("corner_wait_frame");
        force dut.x_r  = 7'd0;
        force dut.dx_r = 1'b0;
        force dut.y_r  = 7'd116;
        force dut.dy_r = 1'b1;
        @(negedge iClock);
        release dut.x_r;
        release dut.dx_r;
        release dut.y_r;
        release dut.dy_r;
        m_x = 0; m_dx = 1'b0; m_y = 116; m_dy = 1'b1;
        do_move(3'b101);
        wait_q_size(0, "corner_drain1");
        wait_frame_state("corner_wait_frame2");
        do_move(3'b101);
        wait_q_size(0, "corner_drain2");

        // Enable drop during ERASE_WAIT: redraw completes, then idle
        wait_frame_state("drop_wait_frame");
        do_move(3'b101);
        wait_q_size(2, "drop_reach_erase_wait");
        iEnable = 1'b0;
        wait_q_size(0, "drop_redraw_drain");
        repeat (80) @(negedge iClock);
        #1;
        check_value("drop_idle_busy", {31'd0, oBusy}, 32'd0);
        check_value("drop_no_extra_strobes", exp_q.size(), 32'd0);
        push_draw(3'b101);
        iEnable = 1'b1;
        wait_q_size(0, "reenable_redraw_drain");

        // Reset in the middle of ERASE_Y
        wait_frame_state("reset_wait_frame");
        do_move(3'b101);
        wait_q_size(3, "reset_reach_erase_gap");
        @(posedge iClock);
        #1;
        iResetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        m_x = 0; m_y = 0; m_dx = 1'b1; m_dy = 1'b1;
        @(negedge iClock);
        #1;
        check_outputs_zero("midreset_held");
        iColour = 3'b011;
        push_draw(3'b011);
        iResetn = 1'b1;
        wait_q_size(0, "post_reset_draw_drain");

        repeat (5) @(negedge iClock);
        check_value("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/box_animator.md
# box_animator

Upstream controller for the box plotter. Drives the plotter's load/plot handshake to animate a BOX_SIZE×BOX_SIZE box that moves one pixel diagonally per move period and bounces off the screen edges. Each move erases the box at its old position in black, steps the position, then redraws it in the selected colour. Outputs connect directly to the plotter's iLoadX, iPlotBox, iXY_Coord and iColour; the plotter's oDone feeds back into iDone.

## Interface
- X_SCREEN_PIXELS, 160, screen width
- Y_SCREEN_PIXELS, 120, screen height
- BOX_SIZE, 4, box edge in pixels
- FRAME_DIV, 833334, iClock cycles per frame tick (60 Hz at 50 MHz)
- FRAMES_PER_MOVE, 15, frame ticks between moves
- DRAW_WAIT, 24, minimum cycles after the oPlotBox pulse before iDone is honoured
- iClock  in  1  sole clock, rising edge
- iResetn  in  1  reset, asynchronous, active-low
- iEnable  in  1  run animation while high
- iColour  in  3  box colour, sampled at each DRAW_Y
- iDone  in  1  plotter completion, level-sensitive; may still be high from the previous box
- oLoadX  out  1  one-cycle X-load strobe
- oPlotBox  out  1  one-cycle Y/colour-load and plot strobe
- oXY_Coord  out  7  coordinate bus (X during oLoadX, Y during oPlotBox)
- oColour  out  3  colour, valid during oPlotBox
- oBusy  out  1  high in every state except IDLE and WAIT_FRAME

## Operation
- Position registers x[6:0] and y[6:0]; direction bits dx and dy (1 = +1, 0 = −1).
- X_MAX = min(127, X_SCREEN_PIXELS−BOX_SIZE) = 127. Y_MAX = Y_SCREEN_PIXELS−BOX_SIZE = 116.
- Reset state: x=0, y=0, dx=1, dy=1, state IDLE, all outputs 0.
- FSM states:
  - IDLE: if iEnable, go to DRAW_X.
  - DRAW_X: oXY_Coord=x, oLoadX=1.
  - DRAW_GAP: all strobes 0.
  - DRAW_Y: oXY_Coord=y, oColour=iColour, oPlotBox=1.
  - DRAW_WAIT: wait counter runs from 0. Exit when counter ≥ DRAW_WAIT−1 and iDone=1. Then go to WAIT_FRAME if iEnable, else IDLE.
  - WAIT_FRAME: frame-tick count cleared on entry. After FRAMES_PER_MOVE ticks, go to ERASE_X. If iEnable drops, go to IDLE.
  - ERASE_X, ERASE_GAP, ERASE_Y, ERASE_WAIT: same as the DRAW_* states, but oColour=3'b000 during ERASE_Y and ERASE_WAIT exits to MOVE.
  - MOVE: one cycle; update position, then go to DRAW_X.
- MOVE arithmetic, per axis independently:
  - if dx=1 and x==X_MAX: dx←0, x←x−1
  - if dx=0 and x==0: dx←1, x←x+1
  - otherwise x←x±1
  - y uses the same rules with Y_MAX. In a corner both axes flip in the same cycle.
- The position therefore always satisfies 0≤x≤X_MAX and 0≤y≤Y_MAX.
- If iEnable drops mid-sequence, the current ERASE or DRAW sequence completes, including MOVE and the redraw, then the FSM parks in IDLE. Position is retained; re-enable redraws at the current position.
- The frame divider is free-running from reset. It counts 0..FRAME_DIV−1 and pulses a one-cycle tick when the count reaches FRAME_DIV−1.

## Timing
- All outputs are registered. Strobes are exactly one cycle wide, with at least one idle cycle between oLoadX and oPlotBox.
- oXY_Coord is stable for the whole strobe cycle. Outside strobe cycles it holds its last value.
- Latency from iEnable rising in IDLE:
  - oLoadX high on the 2nd rising edge (IDLE→DRAW_X, then registered output).
  - oPlotBox high 2 cycles after oLoadX.
- Move period: FRAMES_PER_MOVE ticks, measured from entry to WAIT_FRAME, plus the erase/move/draw overhead.
- A sticky iDone=1 must not shorten DRAW_WAIT or ERASE_WAIT below DRAW_WAIT cycles.
- Asynchronous reset at any point returns the block to IDLE at the reset position on the same cycle, with strobes forced to 0. No partial strobe is allowed.

## Structure
- Package box_anim_pkg holds:
  - the state enum
  - the derived constants X_MAX and Y_MAX
  - widths: COORD_W=7, COLOUR_W=3
- Sub-module frame_tick_gen (parameter FRAME_DIV): free-running counter with a one-cycle tick output, using the same clock and reset.
- Everything else (FSM, position/direction registers, wait counter) lives in box_animator.

## Test plan
Benches use FRAME_DIV=4, FRAMES_PER_MOVE=2 and DRAW_WAIT=24, with iDone modelled as sticky-high after the first plot.
- Reset: assert iResetn=0 mid-ERASE_Y → all outputs 0 immediately; after release with iEnable=1, the next oLoadX carries oXY_Coord=0.
- First draw: iEnable=1, iColour=3'b101 → oLoadX with coord 0, one gap cycle, then oPlotBox with coord 0 and colour 5. The next strobe appears no earlier than 24 cycles later.
- Move cadence: from (0,0), expect:
  - erase: oLoadX coord 0, oPlotBox coord 0, colour 0
  - then draw: oLoadX coord 1, oPlotBox coord 1, colour 5
- X bounce: force the state to x=127, dx=1, y=50, dy=1 → next draw is at x=126, y=51; the following draw is at x=125.
- Corner: x=0, dx=0, y=116, dy=1 → next draw is at (1,115), with both directions flipped.
- Enable drop: deassert iEnable during ERASE_WAIT → the redraw completes, then the block sits in IDLE with oBusy=0 and no further strobes. Re-enabling redraws at the same coordinates.
